// File: rtl/mips_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_unit_if
// Description : Bundles the fetch stage's Avalon-style instruction read port,
//               the instruction valid/ready delivery port, the redirect inputs
//               and the run status flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_fetch_unit_if;
    // Avalon-style instruction read port
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    // Instruction delivery to control unit / datapath
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    // Branch/jump redirect from the consumer
    logic        redirect_valid;
    logic [31:0] redirect_target;

    // Run status
    logic        active;

    // Fetch unit side
    modport master (
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata,
        output instr_valid, instr, instr_pc, opcode, funct,
        input  instr_ready,
        input  redirect_valid, redirect_target,
        output active
    );

    // Memory / consumer side
    modport slave (
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata,
        input  instr_valid, instr, instr_pc, opcode, funct,
        output instr_ready,
        output redirect_valid, redirect_target,
        input  active
    );
endinterface
`default_nettype wire

// File: rtl/mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_unit
// Description : MIPS instruction fetch stage. Owns the PC, issues instruction
//               reads, holds each returned word in a one-entry output register
//               and handles branch/jump redirects with one delay slot. A fetch
//               to address 0 halts the unit until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  wire               clk,
    input  wire               reset,    // synchronous, active-low
    mips_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        avm_read_q;
    logic        instr_valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        active_q;
    logic        pending_q;
    logic        in_slot_q;
    logic [31:0] pending_target_q;

    logic [31:0] next_pc_d;
    logic        take_branch_d;

    // Target low bits are discarded on purpose; sink them explicitly.
    logic        unused_target_bits;
    assign unused_target_bits = &{1'b0, bus.redirect_target[1:0]};

    // Address of the instruction following the one currently held.
    // A redirect seen on a delay-slot instruction is ignored: first target wins.
    always_comb begin
        next_pc_d     = instr_pc_q + 32'd4;
        take_branch_d = 1'b0;
        if (bus.redirect_valid && !in_slot_q) begin
            take_branch_d = 1'b1;
        end else if (in_slot_q && pending_q) begin
            next_pc_d = pending_target_q;
        end
    end

    // Fetch state machine; every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= S_FETCH;
            pc_q             <= RESET_VECTOR;
            avm_read_q       <= 1'b0;
            instr_valid_q    <= 1'b0;
            instr_q          <= 32'd0;
            instr_pc_q       <= 32'd0;
            active_q         <= 1'b0;
            pending_q        <= 1'b0;
            in_slot_q        <= 1'b0;
            pending_target_q <= 32'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    active_q <= 1'b1;
                    if (!avm_read_q) begin
                        // First cycle out of reset: start the read.
                        avm_read_q <= 1'b1;
                    end else if (!bus.avm_waitrequest) begin
                        instr_q       <= bus.avm_readdata;
                        instr_pc_q    <= pc_q;
                        avm_read_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.instr_ready) begin
                        if (take_branch_d) begin
                            pending_target_q <= {bus.redirect_target[31:2], 2'b00};
                            pending_q        <= 1'b1;
                            in_slot_q        <= 1'b1;
                        end else if (in_slot_q) begin
                            pending_q <= 1'b0;
                            in_slot_q <= 1'b0;
                        end
                        instr_valid_q <= 1'b0;
                        if (next_pc_d == 32'd0) begin
                            active_q <= 1'b0;
                            state_q  <= S_HALTED;
                        end else begin
                            pc_q       <= next_pc_d;
                            avm_read_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_HALTED: begin
                    avm_read_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    active_q      <= 1'b0;
                end
                default: begin
                    state_q <= S_HALTED;
                end
            endcase
        end
    end

    assign bus.avm_address = pc_q;
    assign bus.avm_read    = avm_read_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.funct       = instr_q[5:0];
    assign bus.active      = active_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_fetch_unit
// Description : Directed self-checking bench for mips_fetch_unit: sequential
//               fetch, wait states, backpressure, branch delay slot, halt and
//               reset during a stalled read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_fetch_unit;

    localparam logic [31:0] C_RV = 32'hBFC00000;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mips_fetch_unit_if bus_if ();

    mips_fetch_unit #(.RESET_VECTOR(C_RV)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'hBFC00000: mem_word = 32'h24020005;
            32'hBFC00004: mem_word = 32'h00000000;
            default:      mem_word = {addr[15:0], 16'hA5C3};
        endcase
    endfunction

    assign bus_if.avm_readdata = mem_word(bus_if.avm_address);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Unit is in FETCH at exp_addr with zero wait states: check the request,
    // let it complete, then check the delivered instruction.
    task automatic fetch_and_check(input string tag, input logic [31:0] exp_addr);
        check_eq({tag, "_read"}, {31'd0, bus_if.avm_read}, 32'd1);
        check_eq({tag, "_addr"}, bus_if.avm_address, exp_addr);
        step();
        check_eq({tag, "_valid"}, {31'd0, bus_if.instr_valid}, 32'd1);
        check_eq({tag, "_pc"}, bus_if.instr_pc, exp_addr);
        check_eq({tag, "_instr"}, bus_if.instr, mem_word(exp_addr));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset                  = 1'b0;
        bus_if.avm_waitrequest = 1'b0;
        bus_if.instr_ready     = 1'b0;
        bus_if.redirect_valid  = 1'b0;
        bus_if.redirect_target = 32'd0;
        @(negedge clk);
        repeat (3) step();

        // Reset values
        check_eq("rst_read",   {31'd0, bus_if.avm_read},    32'd0);
        check_eq("rst_addr",   bus_if.avm_address,          C_RV);
        check_eq("rst_valid",  {31'd0, bus_if.instr_valid}, 32'd0);
        check_eq("rst_instr",  bus_if.instr,                32'd0);
        check_eq("rst_pc",     bus_if.instr_pc,             32'd0);
        check_eq("rst_active", {31'd0, bus_if.active},      32'd0);

        // Sequential fetch
        reset = 1'b1;
        bus_if.instr_ready = 1'b1;
        step();
        check_eq("e0_active", {31'd0, bus_if.active}, 32'd1);
        check_eq("e0_valid",  {31'd0, bus_if.instr_valid}, 32'd0);
        fetch_and_check("seq0", C_RV);
        check_eq("seq0_opcode", {26'd0, bus_if.opcode}, 32'h09);
        check_eq("seq0_funct",  {26'd0, bus_if.funct},  32'h05);
        check_eq("seq0_noread", {31'd0, bus_if.avm_read}, 32'd0);
        step();
        check_eq("seq_accept_valid", {31'd0, bus_if.instr_valid}, 32'd0);
        fetch_and_check("seq1", 32'hBFC00004);

        // Wait states: three stalled cycles on the read at 0xBFC00008
        bus_if.avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("ws_read",  {31'd0, bus_if.avm_read},    32'd1);
            check_eq("ws_addr",  bus_if.avm_address,          32'hBFC00008);
            check_eq("ws_valid", {31'd0, bus_if.instr_valid}, 32'd0);
        end
        bus_if.avm_waitrequest = 1'b0;
        bus_if.instr_ready     = 1'b0;
        step();
        check_eq("ws_rise_valid", {31'd0, bus_if.instr_valid}, 32'd1);
        check_eq("ws_pc",         bus_if.instr_pc,             32'hBFC00008);
        check_eq("ws_instr",      bus_if.instr,                32'h0008A5C3);

        // Backpressure: held four cycles, no read issued
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("bp_valid", {31'd0, bus_if.instr_valid}, 32'd1);
            check_eq("bp_instr", bus_if.instr,                32'h0008A5C3);
            check_eq("bp_read",  {31'd0, bus_if.avm_read},    32'd0);
        end
        bus_if.instr_ready = 1'b1;
        step();
        fetch_and_check("seq3", 32'hBFC0000C);
        step();
        fetch_and_check("br", 32'hBFC00010);

        // Branch with delay slot; low target bits cleared
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'hBFC00103;
        step();
        bus_if.redirect_valid = 1'b0;
        fetch_and_check("slot", 32'hBFC00014);

        // Redirect during delay slot is ignored
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'hBFC00200;
        step();
        bus_if.redirect_valid = 1'b0;
        fetch_and_check("tgt", 32'hBFC00100);
        step();
        fetch_and_check("tgt1", 32'hBFC00104);

        // Jump to 0: delay slot delivered, then halted
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'h00000000;
        step();
        bus_if.redirect_valid = 1'b0;
        fetch_and_check("hslot", 32'hBFC00108);
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("halt_active", {31'd0, bus_if.active},      32'd0);
            check_eq("halt_read",   {31'd0, bus_if.avm_read},    32'd0);
            check_eq("halt_valid",  {31'd0, bus_if.instr_valid}, 32'd0);
            step();
        end

        // Reset during a stalled read
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus_if.avm_waitrequest = 1'b1;
        step();
        check_eq("mr_read", {31'd0, bus_if.avm_read}, 32'd1);
        step();
        check_eq("mr_stall_valid", {31'd0, bus_if.instr_valid}, 32'd0);
        reset = 1'b0;
        step();
        check_eq("mr_rst_read",   {31'd0, bus_if.avm_read},    32'd0);
        check_eq("mr_rst_valid",  {31'd0, bus_if.instr_valid}, 32'd0);
        check_eq("mr_rst_active", {31'd0, bus_if.active},      32'd0);
        bus_if.avm_waitrequest = 1'b0;
        step();
        check_eq("mr_rst2_valid", {31'd0, bus_if.instr_valid}, 32'd0);
        reset = 1'b1;
        step();
        check_eq("mr_rel_active", {31'd0, bus_if.active}, 32'd1);
        fetch_and_check("mr_first", C_RV);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
